mem_bus_arbiter: RTL and testbench

Sequences the single shared memory bus between the IF-stage instruction fetch port and the MEM-stage data port of the pipelined CPU. It consumes the 4-bit memory-access code produced in MEM, aligns store data, generates byte enables, extends load results, and runs a req/ack bus handshake with timeout. It detects misaligned accesses. The pipeline stalls on each port until that port's ready pulse.

---
 rtl/mem_bus_arbiter_pkg.sv | 37 +++
 rtl/mem_bus_arbiter_lane_unit.sv | 97 +++++++++
 rtl/mem_bus_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter.
//   - Memory-access codes produced by the MEM stage (mem_code).
//   - Exception codes reported on mem_exc alongside mem_ready.
//   - Arbiter FSM state encoding.
// The CPU pipeline and the access coder use the same constants, so any
// change here must be mirrored on the producer side.
package mem_bus_arbiter_pkg;

    localparam logic [3:0] MC_LW   = 4'd0;
    localparam logic [3:0] MC_SW   = 4'd1;
    localparam logic [3:0] MC_LH   = 4'd2;
    localparam logic [3:0] MC_LB   = 4'd3;
    localparam logic [3:0] MC_LHU  = 4'd4;
    localparam logic [3:0] MC_LBU  = 4'd5;
    localparam logic [3:0] MC_SH   = 4'd6;
    localparam logic [3:0] MC_SB   = 4'd7;
    localparam logic [3:0] MC_NONE = 4'd8;

    localparam logic [1:0] EXC_OK   = 2'd0;
    localparam logic [1:0] EXC_ADEL = 2'd1;
    localparam logic [1:0] EXC_ADES = 2'd2;
    localparam logic [1:0] EXC_TMO  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUS_D  = 3'd1,
        ST_BUS_I  = 3'd2,
        ST_DONE_D = 3'd3,
        ST_DONE_I = 3'd4
    } state_t;

    // Codes 8..15 all mean "no data access this cycle".
    function automatic logic is_data_req(input logic [3:0] code);
        return (code <= MC_SB);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_lane_unit.sv
// mem_lane_unit: combinational byte-lane logic for the data port.
// Ports:
//   code      in  4   memory-access code
//   addr_lo   in  2   low two bits of the byte address
//   wdata     in  32  right-justified store data
//   bus_word  in  32  word returned by the bus
//   be        out 4   byte enables (bit i = lane i, little-endian)
//   wdata_al  out 32  store data replicated onto the addressed lanes
//   misalign  out 1   access violates natural alignment
//   is_store  out 1   code is a store
//   load_val  out 32  selected and extended load result
module mem_lane_unit
    import mem_bus_arbiter_pkg::*;
(
    input  logic [3:0]  code,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_word,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic        misalign,
    output logic        is_store,
    output logic [31:0] load_val
);

    function automatic logic [31:0] sext16(input logic signed [15:0] h);
        logic signed [31:0] r;
        r = h;
        return r;
    endfunction

    function automatic logic [31:0] sext8(input logic signed [7:0] b);
        logic signed [31:0] r;
        r = b;
        return r;
    endfunction

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = addr_lo[1] ? bus_word[31:16] : bus_word[15:0];
        case (addr_lo)
            2'd0:    byte_sel = bus_word[7:0];
            2'd1:    byte_sel = bus_word[15:8];
            2'd2:    byte_sel = bus_word[23:16];
            default: byte_sel = bus_word[31:24];
        endcase
    end

    always_comb begin
        be       = 4'b1111;
        wdata_al = 32'd0;
        misalign = 1'b0;
        is_store = 1'b0;
        load_val = bus_word;
        case (code)
            MC_LW: begin
                misalign = (addr_lo != 2'd0);
            end
            MC_SW: begin
                is_store = 1'b1;
                wdata_al = wdata;
                misalign = (addr_lo != 2'd0);
            end
            MC_LH: begin
                misalign = addr_lo[0];
                load_val = sext16(half_sel);
            end
            MC_LHU: begin
                misalign = addr_lo[0];
                load_val = {16'd0, half_sel};
            end
            MC_LB: begin
                load_val = sext8(byte_sel);
            end
            MC_LBU: begin
                load_val = {24'd0, byte_sel};
            end
            MC_SH: begin
                is_store = 1'b1;
                misalign = addr_lo[0];
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata[15:0]}};
            end
            MC_SB: begin
                is_store = 1'b1;
                be       = 4'b0001 << addr_lo;
                wdata_al = {4{wdata[7:0]}};
            end
            default: begin
                be = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the instruction-fetch
// port and the data port. Data requests take priority. Each transaction
// runs a req/ack handshake with a timeout; misaligned data accesses are
// rejected without touching the bus.
// Ports:
//   clk, reset (async, active-low)
//   if_req/if_addr            fetch request (level, held until if_ready)
//   if_rdata/if_ready         fetch result, one-cycle pulse
//   mem_code/mem_addr/mem_wdata  data request (code 0..7 = access)
//   mem_rdata/mem_ready/mem_exc  data result, one-cycle pulse
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata  bus request side
//   bus_rdata/bus_ack         bus response side
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic [3:0]  mem_code,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic [1:0]  mem_exc,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        code_q, code_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        exc_q, exc_d;

    logic              in_idle;
    logic              in_bus;
    logic              data_pending;
    logic [3:0]        lane_code;
    logic [1:0]        lane_alo;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic              lane_misalign;
    logic              lane_is_store;
    logic [31:0]       lane_load;

    assign in_idle      = (state_q == ST_IDLE);
    assign in_bus       = (state_q == ST_BUS_D) || (state_q == ST_BUS_I);
    assign data_pending = is_data_req(mem_code);

    // One lane unit serves both phases: in IDLE it decodes the live request
    // (enables, store alignment, misalign check); during BUS_D it extends
    // the returning word using the latched code and address.
    assign lane_code = in_idle ? mem_code      : code_q;
    assign lane_alo  = in_idle ? mem_addr[1:0] : addr_q[1:0];

    mem_lane_unit u_lane (
        .code     (lane_code),
        .addr_lo  (lane_alo),
        .wdata    (mem_wdata),
        .bus_word (bus_rdata),
        .be       (lane_be),
        .wdata_al (lane_wdata),
        .misalign (lane_misalign),
        .is_store (lane_is_store),
        .load_val (lane_load)
    );

    // State register and timeout counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (data_pending) begin
                    state_d = lane_misalign ? ST_DONE_D : ST_BUS_D;
                end else if (if_req) begin
                    state_d = ST_BUS_I;
                end
            end
            ST_BUS_D: begin
                if (bus_ack || (cnt_q == CNT_LAST)) begin
                    state_d = ST_DONE_D;
                end
            end
            ST_BUS_I: begin
                if (bus_ack || (cnt_q == CNT_LAST)) begin
                    state_d = ST_DONE_I;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter and transaction registers
    always_comb begin
        cnt_d   = '0;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        code_d  = code_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        case (state_q)
            ST_IDLE: begin
                if (data_pending) begin
                    addr_d  = mem_addr;
                    code_d  = mem_code;
                    rdata_d = 32'd0;
                    if (lane_misalign) begin
                        exc_d = lane_is_store ? EXC_ADES : EXC_ADEL;
                    end else begin
                        exc_d   = EXC_OK;
                        we_d    = lane_is_store;
                        be_d    = lane_be;
                        wdata_d = lane_wdata;
                    end
                end else if (if_req) begin
                    addr_d  = if_addr;
                    code_d  = MC_LW;
                    we_d    = 1'b0;
                    be_d    = 4'b1111;
                    wdata_d = 32'd0;
                    rdata_d = 32'd0;
                    exc_d   = EXC_OK;
                end
            end
            ST_BUS_D, ST_BUS_I: begin
                cnt_d = cnt_q + 1'b1;
                if (bus_ack) begin
                    if (state_q == ST_BUS_I) begin
                        rdata_d = bus_rdata;
                    end else begin
                        rdata_d = we_q ? 32'd0 : lane_load;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'd0;
                    exc_d   = EXC_TMO;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        we_q    <= we_d;
        be_q    <= be_d;
        wdata_q <= wdata_d;
        code_q  <= code_d;
        rdata_q <= rdata_d;
        exc_q   <= exc_d;
    end

    // Outputs: derived from state so reset clears them immediately
    always_comb begin
        bus_req   = in_bus;
        bus_we    = in_bus ? we_q : 1'b0;
        bus_addr  = in_bus ? {addr_q[31:2], 2'b00} : 32'd0;
        bus_be    = in_bus ? be_q : 4'b0000;
        bus_wdata = (in_bus && we_q) ? wdata_q : 32'd0;
        mem_ready = (state_q == ST_DONE_D);
        mem_rdata = mem_ready ? rdata_q : 32'd0;
        mem_exc   = mem_ready ? exc_q : EXC_OK;
        if_ready  = (state_q == ST_DONE_I);
        if_rdata  = if_ready ? rdata_q : 32'd0;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic [3:0]  mem_code;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [1:0]  mem_exc;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .mem_code  (mem_code),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mem_exc   (mem_exc),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  code;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mis;
        logic [3:0]  be;
        logic        we;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [31:0] erdata;
        logic [1:0]  exc;
    } vec_t;

    vec_t vecs[13];

    // Start in IDLE at a negedge; leaves the DUT in IDLE at a negedge.
    task automatic run_vec(input vec_t v, input int idx);
        mem_code  = v.code;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        @(posedge clk);
        @(negedge clk);
        if (!v.mis) begin
            chk($sformatf("v%0d_req", idx),   {31'd0, bus_req}, 32'd1);
            chk($sformatf("v%0d_we", idx),    {31'd0, bus_we}, {31'd0, v.we});
            chk($sformatf("v%0d_addr", idx),  bus_addr, v.baddr);
            chk($sformatf("v%0d_be", idx),    {28'd0, bus_be}, {28'd0, v.be});
            chk($sformatf("v%0d_wdata", idx), bus_wdata, v.bwdata);
            chk($sformatf("v%0d_early", idx), {31'd0, mem_ready}, 32'd0);
            bus_ack   = 1'b1;
            bus_rdata = v.rdata;
            @(posedge clk);
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = 32'd0;
        end else begin
            chk($sformatf("v%0d_noreq", idx), {31'd0, bus_req}, 32'd0);
        end
        chk($sformatf("v%0d_ready", idx), {31'd0, mem_ready}, 32'd1);
        chk($sformatf("v%0d_rdata", idx), mem_rdata, v.erdata);
        chk($sformatf("v%0d_exc", idx),   {30'd0, mem_exc}, {30'd0, v.exc});
        chk($sformatf("v%0d_ifrdy", idx), {31'd0, if_ready}, 32'd0);
        mem_code = 4'd8;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_pulse", idx), {31'd0, mem_ready}, 32'd0);
    endtask

    initial begin
        int n;
        logic got;

        //           code  addr          wdata          rdata          mis   be       we    baddr         bwdata         erdata         exc
        vecs[0]  = '{4'd0, 32'h0000_0010, 32'h0,        32'h8899_AABB, 1'b0, 4'b1111, 1'b0, 32'h0000_0010, 32'h0,         32'h8899_AABB, 2'd0};
        vecs[1]  = '{4'd3, 32'h0000_0013, 32'h0,        32'h80FF_1234, 1'b0, 4'b1111, 1'b0, 32'h0000_0010, 32'h0,         32'hFFFF_FF80, 2'd0};
        vecs[2]  = '{4'd5, 32'h0000_0013, 32'h0,        32'h80FF_1234, 1'b0, 4'b1111, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0080, 2'd0};
        vecs[3]  = '{4'd6, 32'h0000_0022, 32'h0000_BEEF,32'h5555_5555, 1'b0, 4'b1100, 1'b1, 32'h0000_0020, 32'hBEEF_BEEF, 32'h0,         2'd0};
        vecs[4]  = '{4'd2, 32'h0000_0012, 32'h0,        32'h80FF_1234, 1'b0, 4'b1111, 1'b0, 32'h0000_0010, 32'h0,         32'hFFFF_80FF, 2'd0};
        vecs[5]  = '{4'd4, 32'h0000_0010, 32'h0,        32'h80FF_9234, 1'b0, 4'b1111, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_9234, 2'd0};
        vecs[6]  = '{4'd7, 32'h0000_0011, 32'h0000_00A5,32'h0,         1'b0, 4'b0010, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0,         2'd0};
        vecs[7]  = '{4'd1, 32'h0000_0040, 32'hDEAD_BEEF,32'h0,         1'b0, 4'b1111, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         2'd0};
        vecs[8]  = '{4'd0, 32'h0000_0002, 32'h0,        32'h0,         1'b1, 4'b0000, 1'b0, 32'h0,         32'h0,         32'h0,         2'd1};
        vecs[9]  = '{4'd6, 32'h0000_0005, 32'h0,        32'h0,         1'b1, 4'b0000, 1'b0, 32'h0,         32'h0,         32'h0,         2'd2};
        vecs[10] = '{4'd2, 32'h0000_0001, 32'h0,        32'h0,         1'b1, 4'b0000, 1'b0, 32'h0,         32'h0,         32'h0,         2'd1};
        vecs[11] = '{4'd3, 32'h0000_0006, 32'h0,        32'h1234_5678, 1'b0, 4'b1111, 1'b0, 32'h0000_0004, 32'h0,         32'h0000_0034, 2'd0};
        vecs[12] = '{4'd7, 32'h0000_0003, 32'h1234_5677,32'h0,         1'b0, 4'b1000, 1'b1, 32'h0000_0000, 32'h7777_7777, 32'h0,         2'd0};

        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = 32'd0;
        mem_code  = 4'd8;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        bus_rdata = 32'd0;
        bus_ack   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], i);
        end

        // Data and fetch arrive together: data goes first, fetch follows.
        if_req    = 1'b1;
        if_addr   = 32'h0000_0103;
        mem_code  = 4'd1;
        mem_addr  = 32'h0000_0080;
        mem_wdata = 32'h1122_3344;
        @(posedge clk);
        @(negedge clk);
        chk("arb_d_we", {31'd0, bus_we}, 32'd1);
        chk("arb_d_addr", bus_addr, 32'h0000_0080);
        chk("arb_d_wdata", bus_wdata, 32'h1122_3344);
        bus_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_ack = 1'b0;
        chk("arb_d_ready", {31'd0, mem_ready}, 32'd1);
        chk("arb_d_ifrdy", {31'd0, if_ready}, 32'd0);
        mem_code = 4'd8;
        @(posedge clk);
        @(negedge clk);
        chk("arb_idle_req", {31'd0, bus_req}, 32'd0);
        chk("arb_idle_rdy", {31'd0, mem_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("arb_i_req", {31'd0, bus_req}, 32'd1);
        chk("arb_i_we", {31'd0, bus_we}, 32'd0);
        chk("arb_i_addr", bus_addr, 32'h0000_0100);
        chk("arb_i_be", {28'd0, bus_be}, 32'hF);
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        chk("arb_i_ready", {31'd0, if_ready}, 32'd1);
        chk("arb_i_rdata", if_rdata, 32'hCAFE_F00D);
        chk("arb_i_memrdy", {31'd0, mem_ready}, 32'd0);
        if_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("arb_i_pulse", {31'd0, if_ready}, 32'd0);

        // Stray ack while idle must not complete anything.
        bus_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_ack = 1'b0;
        chk("stray_ack_req", {31'd0, bus_req}, 32'd0);
        chk("stray_ack_rdy", {31'd0, mem_ready | if_ready}, 32'd0);

        // Timeout: no ack ever, bus_req must stay up for exactly 16 cycles.
        mem_code = 4'd0;
        mem_addr = 32'h0000_0020;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_req) n++;
            if (mem_ready) begin
                got = 1'b1;
                chk("tmo_exc", {30'd0, mem_exc}, 32'd3);
                chk("tmo_rdata", mem_rdata, 32'd0);
            end
        end
        chk("tmo_seen", {31'd0, got}, 32'd1);
        chk("tmo_len", n, 32'd16);
        mem_code = 4'd8;
        @(posedge clk);
        @(negedge clk);

        // Reset in the middle of a fetch.
        if_req  = 1'b1;
        if_addr = 32'h0000_0200;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_req_on", {31'd0, bus_req}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstmid_req_off", {31'd0, bus_req}, 32'd0);
        chk("rstmid_addr", bus_addr, 32'd0);
        bus_ack   = 1'b1;
        bus_rdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_ifrdy", {31'd0, if_ready}, 32'd0);
        bus_ack = 1'b0;
        if_req  = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstrel_req", {31'd0, bus_req}, 32'd0);
        chk("rstrel_ifrdy", {31'd0, if_ready}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
